// File: rtl/ddr_arb_pkg.sv
// Shared state encodings and default widths for the two-port DDR AXI arbiter.
package ddr_arb_pkg;

  localparam int unsigned DDR_ARB_ADDR_W = 32;
  localparam int unsigned DDR_ARB_DATA_W = 32;
  localparam int unsigned DDR_ARB_LEN_W  = 8;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;

endpackage

// File: rtl/ddr_arb_pick.sv
// Two-way grant picker. DDR_ARB_RR_EN selects round-robin with a last-grant pointer;
// otherwise port 0 has fixed priority and no pointer exists.
module ddr_arb_pick (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic       o_gnt
);

`ifdef DDR_ARB_RR_EN
  logic r_last;

  // Pointer starts at 1 so port 0 wins the first contested grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (i_take && (|i_req)) begin
      r_last <= o_gnt;
    end
  end

  always_comb begin
    if (&i_req) begin
      o_gnt = ~r_last;
    end else begin
      o_gnt = i_req[1];
    end
  end
`else
  logic w_unused;

  assign w_unused = ^{clk, rst, i_take};
  assign o_gnt    = i_req[1] & ~i_req[0];
`endif

endmodule

// File: rtl/ddr_axi_arbiter.sv
// Two-port AXI4 arbiter in front of a DDR3 controller; independent write and read paths.
// Arbitration is fixed priority unless DDR_ARB_RR_EN is defined (round-robin).
module ddr_axi_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DDR_ARB_ADDR_W,
  parameter int unsigned DATA_W = DDR_ARB_DATA_W,
  parameter int unsigned LEN_W  = DDR_ARB_LEN_W,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic                clk,
  input  logic                rst,
  // upstream write
  input  logic [2*ADDR_W-1:0] s_awaddr,
  input  logic [2*LEN_W-1:0]  s_awlen,
  input  logic [1:0]          s_awvalid,
  output logic [1:0]          s_awready,
  input  logic [2*DATA_W-1:0] s_wdata,
  input  logic [2*STRB_W-1:0] s_wstrb,
  input  logic [1:0]          s_wlast,
  input  logic [1:0]          s_wvalid,
  output logic [1:0]          s_wready,
  output logic [1:0]          s_bvalid,
  input  logic [1:0]          s_bready,
  // upstream read
  input  logic [2*ADDR_W-1:0] s_araddr,
  input  logic [2*LEN_W-1:0]  s_arlen,
  input  logic [1:0]          s_arvalid,
  output logic [1:0]          s_arready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic                s_rlast,
  output logic [1:0]          s_rvalid,
  input  logic [1:0]          s_rready,
  // downstream master
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [LEN_W-1:0]    m_awlen,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [STRB_W-1:0]   m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [LEN_W-1:0]    m_arlen,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready
);

  wr_state_e r_wstate;
  rd_state_e r_rstate;
  logic      r_wgnt;
  logic      r_rgnt;
  logic      w_wpick;
  logic      w_rpick;

  ddr_arb_pick u_wpick (
    .clk    (clk),
    .rst    (rst),
    .i_req  (s_awvalid),
    .i_take (r_wstate == W_IDLE),
    .o_gnt  (w_wpick)
  );

  ddr_arb_pick u_rpick (
    .clk    (clk),
    .rst    (rst),
    .i_req  (s_arvalid),
    .i_take (r_rstate == R_IDLE),
    .o_gnt  (w_rpick)
  );

  // Write path: grant is held from address through response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_wgnt   <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (|s_awvalid) begin
            r_wgnt   <= w_wpick;
            r_wstate <= W_ADDR;
          end
        end
        W_ADDR: if (m_awvalid && m_awready)            r_wstate <= W_DATA;
        W_DATA: if (m_wvalid && m_wready && m_wlast)   r_wstate <= W_RESP;
        W_RESP: if (m_bvalid && m_bready)              r_wstate <= W_IDLE;
        default:                                       r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_rgnt   <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (|s_arvalid) begin
            r_rgnt   <= w_rpick;
            r_rstate <= R_ADDR;
          end
        end
        R_ADDR: if (m_arvalid && m_arready)            r_rstate <= R_DATA;
        R_DATA: if (m_rvalid && m_rready && m_rlast)   r_rstate <= R_IDLE;
        default:                                       r_rstate <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    m_awaddr  = r_wgnt ? s_awaddr[2*ADDR_W-1:ADDR_W] : s_awaddr[ADDR_W-1:0];
    m_awlen   = r_wgnt ? s_awlen[2*LEN_W-1:LEN_W]    : s_awlen[LEN_W-1:0];
    m_wdata   = r_wgnt ? s_wdata[2*DATA_W-1:DATA_W]  : s_wdata[DATA_W-1:0];
    m_wstrb   = r_wgnt ? s_wstrb[2*STRB_W-1:STRB_W]  : s_wstrb[STRB_W-1:0];
    m_wlast   = s_wlast[r_wgnt];
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    case (r_wstate)
      W_ADDR: begin
        m_awvalid         = s_awvalid[r_wgnt];
        s_awready[r_wgnt] = m_awready;
      end
      W_DATA: begin
        m_wvalid         = s_wvalid[r_wgnt];
        s_wready[r_wgnt] = m_wready;
      end
      W_RESP: begin
        m_bready         = s_bready[r_wgnt];
        s_bvalid[r_wgnt] = m_bvalid;
      end
      default: ;
    endcase
  end

  always_comb begin
    m_araddr  = r_rgnt ? s_araddr[2*ADDR_W-1:ADDR_W] : s_araddr[ADDR_W-1:0];
    m_arlen   = r_rgnt ? s_arlen[2*LEN_W-1:LEN_W]    : s_arlen[LEN_W-1:0];
    s_rdata   = m_rdata;
    s_rlast   = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    s_arready = '0;
    s_rvalid  = '0;
    case (r_rstate)
      R_ADDR: begin
        m_arvalid         = s_arvalid[r_rgnt];
        s_arready[r_rgnt] = m_arready;
      end
      R_DATA: begin
        m_rready         = s_rready[r_rgnt];
        s_rvalid[r_rgnt] = m_rvalid;
        s_rlast          = m_rlast;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ddr_axi_arbiter.sv
// Directed bench for ddr_axi_arbiter; expectations follow DDR_ARB_RR_EN when defined.
module tb_ddr_axi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_awaddr;
  logic [15:0] s_awlen;
  logic [1:0]  s_awvalid, s_awready;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic [1:0]  s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [63:0] s_araddr;
  logic [15:0] s_arlen;
  logic [1:0]  s_arvalid, s_arready;
  logic [31:0] s_rdata;
  logic        s_rlast;
  logic [1:0]  s_rvalid, s_rready;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [7:0]  m_awlen, m_arlen;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;

  int checks = 0;
  int errors = 0;

  ddr_axi_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .s_awaddr  (s_awaddr),
    .s_awlen   (s_awlen),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wlast   (s_wlast),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_araddr  (s_araddr),
    .s_arlen   (s_arlen),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rlast   (s_rlast),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .m_awaddr  (m_awaddr),
    .m_awlen   (m_awlen),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wlast   (m_wlast),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rdata   (m_rdata),
    .m_rlast   (m_rlast),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    s_awaddr = '0; s_awlen = '0; s_awvalid = '0;
    s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0; s_bready = '0;
    s_araddr = '0; s_arlen = '0; s_arvalid = '0; s_rready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    m_arready = 1'b0; m_rdata = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
  endtask

  task automatic do_write(input int p, input logic [31:0] addr, input int len);
    logic [1:0]  oh;
    logic [31:0] d;
    logic [3:0]  st;
    oh = 2'b01 << p;
    s_awaddr[p*32 +: 32] = addr;
    s_awlen[p*8 +: 8]    = 8'(len);
    s_awvalid[p]         = 1'b1;
    #1;
    checks++;
    if (m_awvalid !== 1'b0) begin
      errors++; $display("FAIL aw_idle_cycle: got %b required 0", m_awvalid);
    end
    tick();
    checks++;
    if (m_awvalid !== 1'b1 || m_awaddr !== addr || m_awlen !== 8'(len)) begin
      errors++;
      $display("FAIL aw_forward: got valid=%b addr=%h len=%0d required 1 %h %0d",
               m_awvalid, m_awaddr, m_awlen, addr, len);
    end
    checks++;
    if (s_awready !== 2'b00) begin
      errors++; $display("FAIL awready_stall: got %b required 00", s_awready);
    end
    m_awready = 1'b1;
    #1;
    checks++;
    if (s_awready !== oh) begin
      errors++; $display("FAIL awready_route: got %b required %b", s_awready, oh);
    end
    tick();
    s_awvalid[p] = 1'b0;
    m_awready    = 1'b0;
    m_wready     = 1'b1;
    for (int b = 0; b <= len; b++) begin
      d  = 32'hA000_0000 + (p << 12) + b;
      st = 4'(b + 1);
      s_wdata[p*32 +: 32] = d;
      s_wstrb[p*4 +: 4]   = st;
      s_wlast[p]          = (b == len);
      s_wvalid[p]         = 1'b1;
      #1;
      checks++;
      if (m_wvalid !== 1'b1 || m_wdata !== d || m_wstrb !== st || m_wlast !== (b == len)) begin
        errors++;
        $display("FAIL w_beat%0d: got v=%b d=%h s=%h l=%b required 1 %h %h %b",
                 b, m_wvalid, m_wdata, m_wstrb, m_wlast, d, st, (b == len));
      end
      checks++;
      if (s_wready !== oh || m_awvalid !== 1'b0) begin
        errors++;
        $display("FAIL wready_beat%0d: got wready=%b awvalid=%b required %b 0",
                 b, s_wready, m_awvalid, oh);
      end
      tick();
    end
    s_wlast[p] = 1'b0;
    s_bready   = ~oh;
    #1;
    checks++;
    if (m_wvalid !== 1'b0 || s_wready !== 2'b00 || m_bready !== 1'b0) begin
      errors++;
      $display("FAIL w_resp_gate: got wvalid=%b wready=%b bready=%b required 0 00 0",
               m_wvalid, s_wready, m_bready);
    end
    s_wvalid[p] = 1'b0;
    m_wready    = 1'b0;
    s_bready    = oh;
    m_bvalid    = 1'b1;
    #1;
    checks++;
    if (s_bvalid !== oh || m_bready !== 1'b1) begin
      errors++;
      $display("FAIL b_route: got bvalid=%b bready=%b required %b 1", s_bvalid, m_bready, oh);
    end
    tick();
    #1;
    checks++;
    if (s_bvalid !== 2'b00 || m_awvalid !== 1'b0) begin
      errors++;
      $display("FAIL w_back_idle: got bvalid=%b awvalid=%b required 00 0", s_bvalid, m_awvalid);
    end
    m_bvalid = 1'b0;
    s_bready = '0;
  endtask

  // Caller has placed arvalid/araddr/arlen for port p; the read FSM is idle.
  task automatic do_read(input int p, input logic [31:0] addr, input int len,
                         input int stall_beat, input int stall_cycles, input bit drop);
    logic [1:0]  oh;
    logic [31:0] d;
    oh = 2'b01 << p;
    #1;
    checks++;
    if (m_arvalid !== 1'b0) begin
      errors++; $display("FAIL ar_idle_cycle: got %b required 0", m_arvalid);
    end
    tick();
    checks++;
    if (m_arvalid !== 1'b1 || m_araddr !== addr || m_arlen !== 8'(len)) begin
      errors++;
      $display("FAIL ar_forward: got valid=%b addr=%h len=%0d required 1 %h %0d",
               m_arvalid, m_araddr, m_arlen, addr, len);
    end
    m_arready = 1'b1;
    #1;
    checks++;
    if (s_arready !== oh) begin
      errors++; $display("FAIL ar_grant: got arready=%b required %b", s_arready, oh);
    end
    tick();
    m_arready = 1'b0;
    if (drop) s_arvalid[p] = 1'b0;
    for (int b = 0; b <= len; b++) begin
      d       = 32'hD000_0000 + (p << 8) + b;
      m_rvalid = 1'b1;
      m_rdata  = d;
      m_rlast  = (b == len);
      if (b == stall_beat) begin
        for (int k = 0; k < stall_cycles; k++) begin
          s_rready = ~oh;
          #1;
          checks++;
          if (m_rready !== 1'b0 || s_rvalid !== oh || s_rlast !== (b == len)) begin
            errors++;
            $display("FAIL r_stall%0d: got rready=%b rvalid=%b rlast=%b required 0 %b %b",
                     k, m_rready, s_rvalid, s_rlast, oh, (b == len));
          end
          tick();
        end
      end
      s_rready = 2'b11;
      #1;
      checks++;
      if (s_rvalid !== oh || m_rready !== 1'b1 || s_rdata !== d || s_rlast !== (b == len)) begin
        errors++;
        $display("FAIL r_beat%0d: got v=%b rdy=%b d=%h l=%b required %b 1 %h %b",
                 b, s_rvalid, m_rready, s_rdata, s_rlast, oh, d, (b == len));
      end
      tick();
    end
    m_rlast = 1'b0;
    #1;
    checks++;
    if (s_rvalid !== 2'b00 || m_rready !== 1'b0 || m_arvalid !== 1'b0) begin
      errors++;
      $display("FAIL r_back_idle: got rvalid=%b rready=%b arvalid=%b required 00 0 0",
               s_rvalid, m_rready, m_arvalid);
    end
    m_rvalid = 1'b0;
    s_rready = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    s_awvalid = 2'b11; s_arvalid = 2'b11; s_wvalid = 2'b11;
    m_bvalid = 1'b1; m_rvalid = 1'b1; s_bready = 2'b11; s_rready = 2'b11;
    tick();
    tick();
    checks++;
    if ({m_awvalid, m_wvalid, m_arvalid} !== 3'b000) begin
      errors++; $display("FAIL reset_m_valid: got %b required 000", {m_awvalid, m_wvalid, m_arvalid});
    end
    checks++;
    if ({m_bready, m_rready, s_awready, s_wready, s_arready} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ready: got %b required 0",
               {m_bready, m_rready, s_awready, s_wready, s_arready});
    end
    checks++;
    if ({s_bvalid, s_rvalid, s_rlast} !== 5'b0) begin
      errors++; $display("FAIL reset_s_valid: got %b required 0", {s_bvalid, s_rvalid, s_rlast});
    end
    drive_idle();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_burst();
    do_write(0, 32'h0000_0100, 3);
  endtask

  task automatic test_read_arbitration();
    int exp_seq [5];
`ifdef DDR_ARB_RR_EN
    exp_seq = '{0, 1, 0, 1, 1};
`else
    exp_seq = '{0, 0, 0, 0, 1};
`endif
    s_araddr  = {32'h0000_2000, 32'h0000_1000};
    s_arlen   = {8'd2, 8'd1};
    s_arvalid = 2'b11;
    for (int r = 0; r < 5; r++) begin
      if (r == 4) s_arvalid[0] = 1'b0;
      if (exp_seq[r] == 1) do_read(1, 32'h0000_2000, 2, -1, 0, r == 4);
      else                 do_read(0, 32'h0000_1000, 1, -1, 0, 1'b0);
    end
    s_arvalid = '0;
    tick();
  endtask

  task automatic test_concurrent();
    s_awaddr[31:0]  = 32'h0000_0300; s_awlen[7:0]  = 8'd1; s_awvalid[0] = 1'b1;
    s_araddr[63:32] = 32'h0000_4000; s_arlen[15:8] = 8'd1; s_arvalid[1] = 1'b1;
    tick();
    checks++;
    if (m_awvalid !== 1'b1 || m_arvalid !== 1'b1) begin
      errors++; $display("FAIL cc_overlap: got aw=%b ar=%b required 1 1", m_awvalid, m_arvalid);
    end
    checks++;
    if (m_awaddr !== 32'h0000_0300 || m_araddr !== 32'h0000_4000) begin
      errors++; $display("FAIL cc_addr: got %h %h required 300 4000", m_awaddr, m_araddr);
    end
    m_awready = 1'b1; m_arready = 1'b1;
    #1;
    checks++;
    if (s_awready !== 2'b01 || s_arready !== 2'b10) begin
      errors++; $display("FAIL cc_ready: got aw=%b ar=%b required 01 10", s_awready, s_arready);
    end
    tick();
    s_awvalid = '0; s_arvalid = '0; m_awready = 1'b0; m_arready = 1'b0;
    m_wready = 1'b1; s_rready = 2'b10;
    for (int b = 0; b < 2; b++) begin
      s_wdata[31:0] = 32'h5500_0000 + b; s_wstrb[3:0] = 4'hF;
      s_wlast[0] = (b == 1); s_wvalid[0] = 1'b1;
      m_rdata = 32'h6600_0000 + b; m_rlast = (b == 1); m_rvalid = 1'b1;
      #1;
      checks++;
      if (m_wvalid !== 1'b1 || m_wdata !== 32'h5500_0000 + b || s_wready !== 2'b01) begin
        errors++;
        $display("FAIL cc_w%0d: got v=%b d=%h rdy=%b required 1 %h 01",
                 b, m_wvalid, m_wdata, s_wready, 32'h5500_0000 + b);
      end
      checks++;
      if (s_rvalid !== 2'b10 || s_rdata !== 32'h6600_0000 + b || m_rready !== 1'b1) begin
        errors++;
        $display("FAIL cc_r%0d: got v=%b d=%h rdy=%b required 10 %h 1",
                 b, s_rvalid, s_rdata, m_rready, 32'h6600_0000 + b);
      end
      tick();
    end
    s_wvalid = '0; s_wlast = '0; m_wready = 1'b0;
    m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = '0;
    m_bvalid = 1'b1; s_bready = 2'b01;
    #1;
    checks++;
    if (s_bvalid !== 2'b01 || m_bready !== 1'b1 || s_rvalid !== 2'b00) begin
      errors++;
      $display("FAIL cc_b: got bvalid=%b bready=%b rvalid=%b required 01 1 00",
               s_bvalid, m_bready, s_rvalid);
    end
    tick();
    m_bvalid = 1'b0; s_bready = '0;
    tick();
  endtask

  task automatic test_read_backpressure();
    s_araddr[63:32] = 32'h0000_7000;
    s_arlen[15:8]   = 8'd3;
    s_arvalid[1]    = 1'b1;
    do_read(1, 32'h0000_7000, 3, 2, 5, 1'b1);
    tick();
  endtask

  task automatic test_reset_mid_burst();
    s_awaddr[31:0] = 32'h0000_0500; s_awlen[7:0] = 8'd3; s_awvalid[0] = 1'b1;
    tick();
    m_awready = 1'b1;
    tick();
    s_awvalid = '0; m_awready = 1'b0; m_wready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      s_wdata[31:0] = 32'h7700_0000 + b; s_wvalid[0] = 1'b1;
      if (b < 2) tick();
    end
    #1;
    checks++;
    if (m_wvalid !== 1'b1) begin
      errors++; $display("FAIL rm_in_burst: got wvalid=%b required 1", m_wvalid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({m_awvalid, m_wvalid, m_arvalid} !== 3'b000 || s_wready !== 2'b00) begin
      errors++;
      $display("FAIL rm_abort: got valids=%b wready=%b required 000 00",
               {m_awvalid, m_wvalid, m_arvalid}, s_wready);
    end
    tick();
    drive_idle();
    rst = 1'b0;
    tick();
    do_write(1, 32'h0000_0600, 1);
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_arbitration();
    test_concurrent();
    test_read_backpressure();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule

// File: doc/ddr_axi_arbiter.md
DDR_AXI_ARBITER -- requirements
Module: ddr_axi_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width. DATA_W, default 32, data width. LEN_W, default 8, burst length width. STRB_W = DATA_W/8, derived, not overridable.
REQ-002 Clock and reset SHALL be: clk, in, 1, sole clock, rising edge. rst, in, 1, asynchronous, active-high.
REQ-003 Upstream ports (index i=0,1 packed, port i at slice i) SHALL be: s_awaddr in 2*ADDR_W; s_awlen in 2*LEN_W; s_awvalid in 2; s_awready out 2 -- write address.
REQ-004 Upstream write data and response SHALL be: s_wdata in 2*DATA_W; s_wstrb in 2*STRB_W; s_wlast in 2; s_wvalid in 2; s_wready out 2; s_bvalid out 2; s_bready in 2.
REQ-005 Upstream read SHALL be: s_araddr in 2*ADDR_W; s_arlen in 2*LEN_W; s_arvalid in 2; s_arready out 2; s_rdata out DATA_W (shared); s_rlast out 1 (shared); s_rvalid out 2; s_rready in 2.
REQ-006 Downstream SHALL be: the AXI4 master ports of the same names with prefix m_ and single-port widths, aw/w/b/ar/r, towards the DDR3 controller; burst type and ID are not carried.

Function
REQ-007 Write and read paths SHALL be independent FSMs that can be active concurrently.
REQ-008 Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP.
REQ-009 W_IDLE: if any s_awvalid, register wgnt and go to W_ADDR on the next edge. m_awvalid asserts 1 cycle after s_awvalid is first seen.
REQ-010 W_ADDR: m_aw* = s_aw*[wgnt]; s_awready[wgnt] = m_awready; on the m_awvalid&&m_awready edge go to W_DATA.
REQ-011 W_DATA: W channel combinationally routed from wgnt; on the m_wvalid&&m_wready&&m_wlast edge go to W_RESP.
REQ-012 W_RESP: s_bvalid[wgnt] = m_bvalid; m_bready = s_bready[wgnt]; on handshake go to W_IDLE.
REQ-013 Read FSM states: R_IDLE, R_ADDR, R_DATA, with rgnt and the same grant and address timing as REQ-009/010. R_DATA: s_rvalid[rgnt] = m_rvalid, m_rready = s_rready[rgnt]. The final rlast handshake returns to R_IDLE.
REQ-014 A non-granted port SHALL see every ready/valid output at 0. All m_*valid outputs SHALL be 0 in the idle states.
REQ-015 Grant SHALL be held for a whole transaction (awlen+1 or arlen+1 beats plus response); awlen=0 is a single beat. Beats are counted only by handshakes; wlast/rlast alone end the data phase.
REQ-016 Simultaneous requests: the port chosen is set by REQ-020. A request arriving during an active transaction waits and is not dropped.
REQ-017 Upstream valid withdrawn before handshake is an AXI violation; the behaviour is unspecified and is not checked.
REQ-018 An idle cycle of at least 1 clock SHALL separate consecutive grants on the same path.

Reset
REQ-019 While rst=1: FSMs at W_IDLE/R_IDLE; wgnt=rgnt=0; last-grant pointers=1, so port 0 wins first; all valid/ready outputs 0. Reset mid-burst SHALL abort the burst without completing it.

Configuration
REQ-020 Macro DDR_ARB_RR_EN: defined -> round-robin; when both ports request, the one not granted last on that path wins, and the pointer updates on grant. Undefined -> fixed priority; port 0 always wins and the pointers are not implemented.

Structure
REQ-021 Package ddr_arb_pkg SHALL hold the write/read state enums and the default width constants.
REQ-022 Sub-module ddr_arb_pick (2-way grant picker with pointer, honouring DDR_ARB_RR_EN) SHALL be instantiated once per path.

Verification
REQ-023 Port0 write awaddr=0x100, awlen=3, 4 beats -> m_awaddr=0x100 1 cycle after awvalid; 4 W beats forwarded; s_bvalid[0] pulses; port1 outputs stay 0.
REQ-024 Both ports assert arvalid in the same cycle, RR defined -> port0 served, then port1. Repeated twice, the order is 0,1,0,1.
REQ-025 Same stimulus, DDR_ARB_RR_EN undefined, port0 requesting continuously -> port1 never granted until port0 drops.
REQ-026 Port0 write and port1 read concurrently -> both complete; downstream aw and ar overlap in time.
REQ-027 rst asserted during W_DATA beat 2 of 4 -> next cycle all m_*valid=0, FSM in W_IDLE. A new write after reset completes normally.
REQ-028 m_rready back-pressure (s_rready[1]=0 for 5 cycles mid-burst) -> m_rready=0 for those cycles, no beat lost, s_rlast on the final beat only.
